// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared constants, state type and coil-current decode for the PWM controller
package pwm_ctrl_pkg;

  localparam int CNT_W  = 10;
  localparam int IPK_W  = 11;
  localparam int IEST_W = 12;

  localparam logic [CNT_W-1:0]  PERIOD = 10'd480;  // 100 kHz at 48 MHz
  localparam logic [CNT_W-1:0]  MAX_ON = 10'd432;  // 90 % duty
  localparam logic [CNT_W-1:0]  BLANK  = 10'd8;    // leading-edge blanking
  localparam logic [IEST_W-1:0] ILIM   = 12'd2050; // ~10 A hard limit

  localparam logic [IEST_W-1:0] IZERO_CODE = 12'h7FF;
  localparam int                DN_PER_AMP = 205;

  // Largest magnitude the estimate can express; a pegged reading may hide
  // any current above it, so it is treated as over the hard limit.
  localparam logic [IPK_W-1:0]  I_FULL_SCALE = 11'h7FF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_FAULT
  } pwm_state_t;

  // Inverted-format estimate to unsigned magnitude; negative current reads 0.
  function automatic logic [IPK_W-1:0] i_mag_decode(input logic [IEST_W-1:0] code);
    logic [IEST_W-1:0] x;
    x = code ^ IZERO_CODE;
    return x[11] ? '0 : x[10:0];
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// rtl/pwm_period_counter.sv - PWM period counter with wrap detect and period-start pulse
module pwm_period_counter
  import pwm_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             active_next,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             start,
  output logic             period_start
);

  // Last cycle of a running period.
  assign wrap  = active && (cnt == PERIOD - 10'd1);
  // Next cycle is the first of a period: leaving idle or wrapping into a new one.
  assign start = active_next && (!active || wrap);

  // Counter clears whenever the stage is not running and restarts at each period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= start;
      if (!active_next || start) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 10'd1;
      end
    end
  end

endmodule

// File: rtl/pwm_peak_controller.sv
// rtl/pwm_peak_controller.sv - peak-current-mode PWM generator with blanking, max duty and overcurrent latch
module pwm_peak_controller
  import pwm_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [IPK_W-1:0]  ipk_set,
  input  logic [IEST_W-1:0] iest_coil,
  output logic              pwm,
  output logic              period_start,
  output logic [CNT_W-1:0]  on_time,
  output logic              fault
);

  pwm_state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic              wrap;
  logic              start;
  logic              active;
  logic              active_next;
  logic [IPK_W-1:0]  i_mag;
  logic [IEST_W-1:0] ipk_clamp;
  logic [IEST_W-1:0] ipk_lat;
  logic [CNT_W-1:0]  on_acc;
  logic              overcurrent;
  logic              trip;
  pwm_state_t        start_state;

  assign i_mag       = i_mag_decode(iest_coil);
  assign ipk_clamp   = ({1'b0, ipk_set} > ILIM) ? ILIM : {1'b0, ipk_set};
  assign overcurrent = ({1'b0, i_mag} > ILIM) || (i_mag == I_FULL_SCALE);
  assign trip        = ((cnt >= BLANK) && ({1'b0, i_mag} >= ipk_lat)) ||
                       (cnt == MAX_ON - 10'd1);
  // A zero setpoint runs the whole period with the switch off.
  assign start_state = (ipk_clamp == '0) ? ST_OFF : ST_ON;
  assign active      = (state == ST_ON) || (state == ST_OFF);
  assign active_next = (state_nxt == ST_ON) || (state_nxt == ST_OFF);

  pwm_period_counter u_counter (
    .clk          (clk),
    .reset        (reset),
    .active       (active),
    .active_next  (active_next),
    .cnt          (cnt),
    .wrap         (wrap),
    .start        (start),
    .period_start (period_start)
  );

  // Next state: enable, then overcurrent, then period wrap, then peak/max-on trip.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = start_state;
      end
      ST_ON, ST_OFF: begin
        if (!enable)                   state_nxt = ST_IDLE;
        else if (overcurrent)          state_nxt = ST_FAULT;
        else if (wrap)                 state_nxt = start_state;
        else if (state == ST_ON && trip) state_nxt = ST_OFF;
      end
      ST_FAULT: begin
        if (!enable) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register with registered gate drive and fault flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      pwm   <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      pwm   <= (state_nxt == ST_ON);
      fault <= (state_nxt == ST_FAULT);
    end
  end

  // Setpoint is sampled once per period so mid-period changes take effect next period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ipk_lat <= '0;
    end else if (start) begin
      ipk_lat <= ipk_clamp;
    end
  end

  // Count on-cycles within the period and publish the total on its last cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      on_acc  <= '0;
      on_time <= '0;
    end else begin
      if (start) begin
        on_acc <= '0;
      end else if (state == ST_ON) begin
        on_acc <= on_acc + 10'd1;
      end
      if (wrap && enable) begin
        on_time <= on_acc + {9'd0, (state == ST_ON)};
      end
    end
  end

endmodule

// File: tb/tb_pwm_peak_controller.sv
// tb/tb_pwm_peak_controller.sv - randomized self-checking bench for pwm_peak_controller
module tb_pwm_peak_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [10:0] ipk_set;
  logic [11:0] iest_coil;
  logic        pwm;
  logic        period_start;
  logic [9:0]  on_time;
  logic        fault;

  int checks = 0;
  int errors = 0;

  int nh, gp, nps, ps0, ona, psa;

  always #5 clk = ~clk;

  pwm_peak_controller dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ipk_set      (ipk_set),
    .iest_coil    (iest_coil),
    .pwm          (pwm),
    .period_start (period_start),
    .on_time      (on_time),
    .fault        (fault)
  );

  // Current profile: 0 = ramp amp*k, 1 = constant amp, 2 = negative current (-1).
  function automatic int cur(input int mode, input int amp, input int k);
    int v;
    if (mode == 2) return -1;
    v = (mode == 0) ? amp * k : amp;
    if (v > 2046) v = 2046;
    return v;
  endfunction

  function automatic logic [11:0] enc(input int mode, input int amp, input int k);
    logic [11:0] t;
    if (mode == 2) return 12'h900;
    t = 12'(cur(mode, amp, k));
    return t ^ 12'h7FF;
  endfunction

  // Expected on-cycles for one period from the trip rules.
  function automatic int exp_on(input int mode, input int amp, input int ipk);
    if (ipk == 0) return 0;
    for (int k = 0; k < 432; k++) begin
      if (k >= 8 && cur(mode, amp, k) >= ipk) return k + 1;
    end
    return 432;
  endfunction

  task automatic start_run(input int ipk);
    ipk_set   = 11'(ipk);
    iest_coil = 12'h7FF;
    enable    = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop_run();
    enable = 1'b0;
    @(negedge clk);
  endtask

  // Drives one full period from cnt 0 and records what the outputs did.
  task automatic run_period(input int mode, input int amp, input int mid_k, input int mid_ipk,
                            input int next_ipk, output int n_high, output int gaps,
                            output int n_ps, output int ps_first, output int on_after,
                            output int ps_after);
    bit seen_low;
    n_high = 0; gaps = 0; n_ps = 0; ps_first = 0; seen_low = 0;
    for (int k = 0; k < 480; k++) begin
      iest_coil = enc(mode, amp, k);
      if (k == mid_k) ipk_set = 11'(mid_ipk);
      if (k == 479)   ipk_set = 11'(next_ipk);
      if (pwm) begin
        n_high++;
        if (seen_low) gaps++;
      end else begin
        seen_low = 1'b1;
      end
      if (period_start) n_ps++;
      if (k == 0) ps_first = int'(period_start);
      @(negedge clk);
    end
    on_after = int'(on_time);
    ps_after = int'(period_start);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; ipk_set = '0; iest_coil = 12'h7FF;
    repeat (2) @(negedge clk);
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm got=%0b exp=0", pwm); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got=%0b exp=0", period_start); end
    checks++; if (on_time !== 10'd0) begin errors++; $display("FAIL reset_on_time got=%0d exp=0", on_time); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%0b exp=0", fault); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pwm !== 1'b0 || period_start !== 1'b0) begin errors++; $display("FAIL idle_outputs got=%0b%0b exp=00", pwm, period_start); end
  endtask

  task automatic test_peak_trip();
    start_run(410);
    for (int p = 0; p < 2; p++) begin
      run_period(0, 2, -1, 0, 410, nh, gp, nps, ps0, ona, psa);
      checks++; if (nh != 206) begin errors++; $display("FAIL peak_high p%0d got=%0d exp=206", p, nh); end
      checks++; if (gp != 0) begin errors++; $display("FAIL peak_shape p%0d got=%0d exp=0", p, gp); end
      checks++; if (nps != 1 || ps0 != 1 || psa != 1) begin errors++; $display("FAIL peak_ps p%0d got=%0d/%0d/%0d exp=1/1/1", p, nps, ps0, psa); end
      checks++; if (ona != 206) begin errors++; $display("FAIL peak_on_time p%0d got=%0d exp=206", p, ona); end
    end
    stop_run();
    checks++; if (pwm !== 1'b0 || on_time !== 10'd206) begin errors++; $display("FAIL disable_hold got=%0b/%0d exp=0/206", pwm, on_time); end
  endtask

  task automatic test_max_duty();
    start_run(2000);
    run_period(1, 0, -1, 0, 2000, nh, gp, nps, ps0, ona, psa);
    checks++; if (nh != 432 || gp != 0) begin errors++; $display("FAIL maxduty_high got=%0d/%0d exp=432/0", nh, gp); end
    checks++; if (ona != 432) begin errors++; $display("FAIL maxduty_on_time got=%0d exp=432", ona); end
    stop_run();
  endtask

  task automatic test_blanking();
    start_run(410);
    run_period(1, 1000, -1, 0, 410, nh, gp, nps, ps0, ona, psa);
    checks++; if (nh != 9 || gp != 0) begin errors++; $display("FAIL blank_high got=%0d/%0d exp=9/0", nh, gp); end
    checks++; if (ona != 9) begin errors++; $display("FAIL blank_on_time got=%0d exp=9", ona); end
    run_period(2, 0, -1, 0, 410, nh, gp, nps, ps0, ona, psa);
    checks++; if (nh != 432) begin errors++; $display("FAIL negative_high got=%0d exp=432", nh); end
    checks++; if (ona != 432) begin errors++; $display("FAIL negative_on_time got=%0d exp=432", ona); end
    stop_run();
  endtask

  task automatic test_setpoint_latch();
    start_run(410);
    run_period(0, 2, 100, 0, 0, nh, gp, nps, ps0, ona, psa);
    checks++; if (nh != 206 || ona != 206) begin errors++; $display("FAIL latch_cur got=%0d/%0d exp=206/206", nh, ona); end
    run_period(0, 2, -1, 0, 0, nh, gp, nps, ps0, ona, psa);
    checks++; if (nh != 0) begin errors++; $display("FAIL latch_zero_high got=%0d exp=0", nh); end
    checks++; if (ps0 != 1 || nps != 1) begin errors++; $display("FAIL latch_zero_ps got=%0d/%0d exp=1/1", ps0, nps); end
    checks++; if (ona != 0) begin errors++; $display("FAIL latch_zero_on_time got=%0d exp=0", ona); end
    stop_run();
  endtask

  task automatic test_back_to_back();
    int ipk, nxt, mode, amp, e;
    ipk = int'($urandom_range(1, 2000));
    start_run(ipk);
    for (int p = 0; p < 6; p++) begin
      mode = int'($urandom_range(0, 2));
      amp  = (mode == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(0, 2000));
      nxt  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 2000));
      run_period(mode, amp, -1, 0, nxt, nh, gp, nps, ps0, ona, psa);
      e = exp_on(mode, amp, ipk);
      checks++; if (nh != e || gp != 0) begin errors++; $display("FAIL b2b_high p%0d m%0d a%0d i%0d got=%0d/%0d exp=%0d/0", p, mode, amp, ipk, nh, gp, e); end
      checks++; if (ona != e) begin errors++; $display("FAIL b2b_on_time p%0d got=%0d exp=%0d", p, ona, e); end
      checks++; if (ps0 != 1 || nps != 1) begin errors++; $display("FAIL b2b_ps p%0d got=%0d/%0d exp=1/1", p, ps0, nps); end
      ipk = nxt;
    end
    stop_run();
  endtask

  task automatic test_fault();
    int bad;
    start_run(2000);
    for (int k = 0; k <= 50; k++) begin
      iest_coil = (k == 50) ? 12'h000 : 12'h7FF;
      if (k == 50) begin
        checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL fault_pre_pwm got=%0b exp=1", pwm); end
      end
      @(negedge clk);
    end
    checks++; if (pwm !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL fault_entry got=%0b/%0b exp=0/1", pwm, fault); end
    iest_coil = 12'h7FF;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (pwm !== 1'b0 || fault !== 1'b1 || period_start !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fault_hold got=%0d exp=0", bad); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (fault !== 1'b0 || pwm !== 1'b0) begin errors++; $display("FAIL fault_clear got=%0b/%0b exp=0/0", fault, pwm); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (pwm !== 1'b1 || period_start !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL fault_restart got=%0b%0b%0b exp=110", pwm, period_start, fault); end
    run_period(1, 0, -1, 0, 2000, nh, gp, nps, ps0, ona, psa);
    checks++; if (nh != 432 || ona != 432) begin errors++; $display("FAIL fault_resume got=%0d/%0d exp=432/432", nh, ona); end
    stop_run();
  endtask

  task automatic test_async_reset();
    start_run(2000);
    repeat (100) @(negedge clk);
    checks++; if (pwm !== 1'b1 || on_time !== 10'd432) begin errors++; $display("FAIL areset_pre got=%0b/%0d exp=1/432", pwm, on_time); end
    #2 reset = 1'b0;
    #1;
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL areset_pwm got=%0b exp=0", pwm); end
    checks++; if (on_time !== 10'd0 || fault !== 1'b0 || period_start !== 1'b0) begin errors++; $display("FAIL areset_outs got=%0d/%0b/%0b exp=0/0/0", on_time, fault, period_start); end
    @(negedge clk);
    reset = 1'b1;
    checks++; if (period_start !== 1'b0 || pwm !== 1'b0) begin errors++; $display("FAIL areset_release got=%0b%0b exp=00", period_start, pwm); end
    @(negedge clk);
    checks++; if (period_start !== 1'b1 || pwm !== 1'b1) begin errors++; $display("FAIL areset_first_ps got=%0b%0b exp=11", period_start, pwm); end
    stop_run();
  endtask

  initial begin
    test_reset();
    test_peak_trip();
    test_max_duty();
    test_blanking();
    test_setpoint_latch();
    test_back_to_back();
    test_fault();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
